// File: rtl/interrupt_controller.sv
// Vectored N-channel interrupt controller: synchronised request pins,
// fixed priority, nesting via in-service bits and a saved-IE stack.
module interrupt_controller #(
  parameter int NUM_INT = 2,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE = ADDR_WIDTH'(4),
  parameter int VECTOR_STRIDE = 4,
  parameter logic [NUM_INT-1:0] NMI_MASK = NUM_INT'(1),
  parameter logic [NUM_INT-1:0] EDGE_MASK = {NUM_INT{1'b1}},
  parameter int SYNC_STAGES = 2,
  localparam int IDW = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_INT-1:0]    INT_IN,
  input  logic                  EI,
  input  logic                  DI,
  input  logic                  RETI,
  input  logic                  MASK_WE,
  input  logic [NUM_INT-1:0]    MASK_DIN,
  input  logic                  INT_ACK,
  output logic                  INT_REQ,
  output logic [ADDR_WIDTH-1:0] INT_VECTOR,
  output logic [IDW-1:0]        INT_ID,
  output logic                  IE,
  output logic [NUM_INT-1:0]    PENDING,
  output logic [NUM_INT-1:0]    IN_SERVICE
);

  localparam int SPW = $clog2(NUM_INT + 1);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
  logic [NUM_INT-1:0] sync_d [SYNC_STAGES];
  logic [NUM_INT-1:0] prev_q, prev_d;
  logic [NUM_INT-1:0] pending_q, pending_d;
  logic [NUM_INT-1:0] mask_q, mask_d;
  logic [NUM_INT-1:0] in_service_q, in_service_d;
  logic [NUM_INT-1:0] stk_q, stk_d;
  logic [SPW-1:0]     sp_q, sp_d;
  logic               ie_q, ie_d;
  state_t             state_q, state_d;
  logic [IDW-1:0]     id_q, id_d;

  logic [NUM_INT-1:0]    synced;
  logic [NUM_INT-1:0]    rise;
  logic [NUM_INT-1:0]    elig;
  logic [IDW-1:0]        sel;
  logic                  int_req;
  logic                  ack_take;
  logic [NUM_INT-1:0]    ack_oh;
  logic                  ie_pop;
  logic [ADDR_WIDTH-1:0] vec;

  function automatic logic [NUM_INT-1:0] upto(input int i);
    upto = '0;
    for (int j = 0; j < NUM_INT; j++) begin
      if (j <= i) upto[j] = 1'b1;
    end
  endfunction

  always_comb begin
    sync_d[0] = INT_IN;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign prev_d = synced;
  assign rise   = synced & ~prev_q;
  assign mask_d = MASK_WE ? MASK_DIN : mask_q;

  // A channel is blocked while it or any higher-priority one is in service
  always_comb begin
    elig = '0;
    sel  = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      elig[i] = pending_q[i]
              & (NMI_MASK[i] | (ie_q & ~mask_q[i]))
              & ~|(in_service_q & upto(i));
    end
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (elig[i]) sel = IDW'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          state_d = S_REQ;
          id_d    = sel;
        end
      end
      S_REQ: begin
        if (INT_ACK || !elig[id_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    int_req    = (state_q == S_REQ);
    ack_take   = int_req & INT_ACK;
    ack_oh     = ack_take ? (NUM_INT'(1) << id_q) : '0;
    vec        = VECTOR_BASE
               + ADDR_WIDTH'(id_q) * ADDR_WIDTH'(VECTOR_STRIDE);
    INT_REQ    = int_req;
    INT_VECTOR = int_req ? vec : '0;
    INT_ID     = int_req ? id_q : '0;
  end

  // RETI pops before ACK pushes, so both in one cycle net out
  always_comb begin
    stk_d        = stk_q;
    sp_d         = sp_q;
    in_service_d = in_service_q;
    ie_pop       = ie_q;
    ie_d         = ie_q;
    if (RETI && |in_service_q) begin
      ie_pop       = stk_q[sp_q - SPW'(1)];
      sp_d         = sp_q - SPW'(1);
      in_service_d = in_service_q
                   & ~(in_service_q & (~in_service_q + NUM_INT'(1)));
    end
    if (ack_take) begin
      stk_d[sp_d]  = ie_pop;
      sp_d         = sp_d + SPW'(1);
      ie_d         = 1'b0;
      in_service_d = in_service_d | ack_oh;
    end else if (DI) begin
      ie_d = 1'b0;
    end else if (EI) begin
      ie_d = 1'b1;
    end else begin
      ie_d = ie_pop;
    end
  end

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      pending_d[i] = EDGE_MASK[i]
                   ? ((pending_q[i] & ~ack_oh[i]) | rise[i])
                   : synced[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      in_service_q <= '0;
      stk_q        <= '0;
      sp_q         <= '0;
      ie_q         <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      stk_q        <= stk_d;
      sp_q         <= sp_d;
      ie_q         <= ie_d;
    end
  end

  assign IE         = ie_q;
  assign PENDING    = pending_q;
  assign IN_SERVICE = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus random traffic
// checked against a queue-based behavioural model.
module tb_interrupt_controller;

  localparam int N = 2;
  localparam int S = 2;
  localparam logic [N-1:0] NMI = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] int_in = '0;
  logic ei = 1'b0, di = 1'b0, reti = 1'b0, ack = 1'b0;
  logic mask_we = 1'b0;
  logic [N-1:0] mask_din = '0;

  logic d_req, d_id, d_ie;
  logic [15:0] d_vec;
  logic [N-1:0] d_pend, d_isvc;
  logic l_req, l_id, l_ie;
  logic [15:0] l_vec;
  logic [N-1:0] l_pend, l_isvc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  interrupt_controller u_dut (
    .CLK(clk), .RESET(rst), .INT_IN(int_in),
    .EI(ei), .DI(di), .RETI(reti),
    .MASK_WE(mask_we), .MASK_DIN(mask_din), .INT_ACK(ack),
    .INT_REQ(d_req), .INT_VECTOR(d_vec), .INT_ID(d_id),
    .IE(d_ie), .PENDING(d_pend), .IN_SERVICE(d_isvc)
  );

  interrupt_controller #(.EDGE_MASK(2'b01)) u_lvl (
    .CLK(clk), .RESET(rst), .INT_IN(int_in),
    .EI(ei), .DI(di), .RETI(reti),
    .MASK_WE(mask_we), .MASK_DIN(mask_din), .INT_ACK(ack),
    .INT_REQ(l_req), .INT_VECTOR(l_vec), .INT_ID(l_id),
    .IE(l_ie), .PENDING(l_pend), .IN_SERVICE(l_isvc)
  );

  // Behavioural model of the default (all-edge) configuration
  bit [N-1:0] m_hist[$];
  bit         m_stk[$];
  bit         m_ie, m_req;
  bit [N-1:0] m_mask, m_pend, m_isvc;
  int         m_id;

  task automatic model_step();
    bit [N-1:0] syn, prv, rise, elig;
    bit busy, tmp, take;
    int first;
    if (rst) begin
      m_hist.delete();
      for (int k = 0; k <= S; k++) m_hist.push_back('0);
      m_stk.delete();
      m_ie = 0; m_req = 0; m_id = 0;
      m_mask = '0; m_pend = '0; m_isvc = '0;
      return;
    end
    syn = m_hist[S-1];
    prv = m_hist[S];
    rise = syn & ~prv;
    elig = '0;
    first = -1;
    for (int i = 0; i < N; i++) begin
      busy = 0;
      for (int j = 0; j <= i; j++) busy |= m_isvc[j];
      elig[i] = m_pend[i] && (NMI[i] || (m_ie && !m_mask[i])) && !busy;
      if (elig[i] && first < 0) first = i;
    end
    take = m_req && ack;
    if (take) m_pend[m_id] = 0;
    m_pend |= rise;
    tmp = m_ie;
    if (reti && m_isvc != 0) begin
      tmp = m_stk.pop_back();
      for (int i = 0; i < N; i++) begin
        if (m_isvc[i]) begin
          m_isvc[i] = 0;
          break;
        end
      end
    end
    if (take) begin
      m_stk.push_back(tmp);
      m_ie = 0;
      m_isvc[m_id] = 1;
    end else if (di) m_ie = 0;
    else if (ei) m_ie = 1;
    else m_ie = tmp;
    if (mask_we) m_mask = mask_din;
    if (!m_req) begin
      if (first >= 0) begin
        m_req = 1;
        m_id = first;
      end
    end else if (ack || !elig[m_id]) m_req = 0;
    m_hist.push_front(int_in);
    void'(m_hist.pop_back());
  endtask

  always @(posedge clk) model_step();

  task automatic wait_req(input bit lvl, input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if ((lvl ? l_req : d_req) === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++; if (d_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%h exp=0", d_req); end
    checks++; if (d_vec !== 16'h0) begin failures++; $display("FAIL rst_vec got=%h exp=0", d_vec); end
    checks++; if (d_id !== 1'b0) begin failures++; $display("FAIL rst_id got=%h exp=0", d_id); end
    checks++; if (d_ie !== 1'b0) begin failures++; $display("FAIL rst_ie got=%h exp=0", d_ie); end
    checks++; if (d_pend !== 2'b00) begin failures++; $display("FAIL rst_pend got=%b exp=00", d_pend); end
    checks++; if (d_isvc !== 2'b00) begin failures++; $display("FAIL rst_isvc got=%b exp=00", d_isvc); end
    checks++;
    if ({l_req, l_vec, l_id, l_ie, l_pend, l_isvc} !== '0) begin
      failures++;
      $display("FAIL rst_lvl got=%h exp=0", {l_req, l_vec, l_id, l_ie, l_pend, l_isvc});
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_nmi();
    int n;
    int_in = 2'b01;
    idle(3);
    checks++; if (d_pend !== 2'b01 || d_req !== 1'b0) begin failures++; $display("FAIL nmi_pend got=%b/%b exp=01/0", d_pend, d_req); end
    wait_req(0, 4, n);
    checks++; if (n !== 1) begin failures++; $display("FAIL nmi_latency got=%0d exp=1", n); end
    checks++; if (d_vec !== 16'h0004 || d_id !== 1'b0) begin failures++; $display("FAIL nmi_vec got=%h/%h exp=0004/0", d_vec, d_id); end
    int_in = 2'b00;
    ack = 1'b1; ei = 1'b1;
    idle(1);
    ack = 1'b0; ei = 1'b0;
    checks++; if (d_ie !== 1'b0) begin failures++; $display("FAIL nmi_ack_ie got=%h exp=0", d_ie); end
    checks++; if (d_isvc !== 2'b01) begin failures++; $display("FAIL nmi_isvc got=%b exp=01", d_isvc); end
    checks++; if (d_req !== 1'b0 || d_pend !== 2'b00) begin failures++; $display("FAIL nmi_clr got=%b/%b exp=0/00", d_req, d_pend); end
    reti = 1'b1;
    idle(1);
    reti = 1'b0;
    checks++; if (d_isvc !== 2'b00 || d_ie !== 1'b0) begin failures++; $display("FAIL nmi_reti got=%b/%b exp=00/0", d_isvc, d_ie); end
  endtask

  task automatic test_ie_gate();
    int n;
    idle(4);
    ei = 1'b1; di = 1'b1;
    idle(1);
    ei = 1'b0; di = 1'b0;
    checks++; if (d_ie !== 1'b0) begin failures++; $display("FAIL eidi_ie got=%h exp=0", d_ie); end
    int_in = 2'b10;
    idle(6);
    checks++; if (d_req !== 1'b0 || d_pend !== 2'b10) begin failures++; $display("FAIL gate_hold got=%b/%b exp=0/10", d_req, d_pend); end
    ei = 1'b1;
    idle(1);
    ei = 1'b0;
    checks++; if (d_ie !== 1'b1) begin failures++; $display("FAIL gate_ei got=%h exp=1", d_ie); end
    wait_req(0, 4, n);
    checks++; if (n !== 1 || d_vec !== 16'h0008 || d_id !== 1'b1) begin failures++; $display("FAIL gate_req got=%0d/%h/%h exp=1/0008/1", n, d_vec, d_id); end
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    checks++; if ({d_ie, d_isvc, d_pend, d_req} !== 6'b0_10_00_0) begin failures++; $display("FAIL gate_ack got=%b exp=010000", {d_ie, d_isvc, d_pend, d_req}); end
  endtask

  task automatic test_nested();
    int n;
    idle(4);
    int_in = 2'b11;
    wait_req(0, 8, n);
    checks++; if (n !== 4 || d_vec !== 16'h0004) begin failures++; $display("FAIL nest_req got=%0d/%h exp=4/0004", n, d_vec); end
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    int_in = 2'b00;
    checks++; if (d_isvc !== 2'b11 || d_ie !== 1'b0) begin failures++; $display("FAIL nest_ack got=%b/%b exp=11/0", d_isvc, d_ie); end
    reti = 1'b1;
    idle(1);
    reti = 1'b0;
    checks++; if (d_isvc !== 2'b10 || d_ie !== 1'b0 || d_req !== 1'b0) begin failures++; $display("FAIL nest_reti1 got=%b/%b/%b exp=10/0/0", d_isvc, d_ie, d_req); end
    reti = 1'b1;
    idle(1);
    reti = 1'b0;
    checks++; if (d_isvc !== 2'b00 || d_ie !== 1'b1) begin failures++; $display("FAIL nest_reti2 got=%b/%b exp=00/1", d_isvc, d_ie); end
  endtask

  task automatic test_simultaneous();
    int n;
    idle(4);
    int_in = 2'b11;
    wait_req(0, 8, n);
    checks++; if (n !== 4 || d_vec !== 16'h0004 || d_id !== 1'b0) begin failures++; $display("FAIL sim_first got=%0d/%h/%h exp=4/0004/0", n, d_vec, d_id); end
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    checks++; if ({d_ie, d_isvc, d_pend} !== 5'b0_01_10) begin failures++; $display("FAIL sim_ack got=%b exp=00110", {d_ie, d_isvc, d_pend}); end
    reti = 1'b1;
    idle(1);
    reti = 1'b0;
    wait_req(0, 3, n);
    checks++; if (n !== 1 || d_vec !== 16'h0008 || d_id !== 1'b1) begin failures++; $display("FAIL sim_second got=%0d/%h/%h exp=1/0008/1", n, d_vec, d_id); end
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    reti = 1'b1;
    idle(1);
    reti = 1'b0;
    int_in = 2'b00;
    checks++; if (d_ie !== 1'b1 || d_isvc !== 2'b00) begin failures++; $display("FAIL sim_done got=%b/%b exp=1/00", d_ie, d_isvc); end
  endtask

  task automatic test_withdraw();
    int n;
    idle(4);
    int_in = 2'b10;
    wait_req(0, 8, n);
    checks++; if (n !== 4 || d_vec !== 16'h0008) begin failures++; $display("FAIL wd_req got=%0d/%h exp=4/0008", n, d_vec); end
    di = 1'b1;
    idle(1);
    di = 1'b0;
    idle(1);
    checks++; if ({d_req, d_pend, d_ie} !== 4'b0_10_0) begin failures++; $display("FAIL wd_drop got=%b exp=0100", {d_req, d_pend, d_ie}); end
    int_in = 2'b00;
    ei = 1'b1;
    idle(1);
    ei = 1'b0;
    wait_req(0, 4, n);
    checks++; if (n !== 1 || d_vec !== 16'h0008) begin failures++; $display("FAIL wd_reissue got=%0d/%h exp=1/0008", n, d_vec); end
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    reti = 1'b1;
    idle(1);
    reti = 1'b0;
    checks++; if (d_isvc !== 2'b00 || d_ie !== 1'b1) begin failures++; $display("FAIL wd_done got=%b/%b exp=00/1", d_isvc, d_ie); end
  endtask

  task automatic test_level_reset();
    int n;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    ei = 1'b1;
    idle(1);
    ei = 1'b0;
    int_in = 2'b10;
    wait_req(1, 8, n);
    checks++; if (n !== 4 || l_vec !== 16'h0008 || l_pend !== 2'b10) begin failures++; $display("FAIL lvl_req got=%0d/%h/%b exp=4/0008/10", n, l_vec, l_pend); end
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    checks++; if ({l_req, l_isvc, l_pend, l_ie} !== 6'b0_10_10_0) begin failures++; $display("FAIL lvl_ack got=%b exp=010100", {l_req, l_isvc, l_pend, l_ie}); end
    reti = 1'b1;
    idle(1);
    reti = 1'b0;
    wait_req(1, 3, n);
    checks++; if (n !== 1 || l_vec !== 16'h0008) begin failures++; $display("FAIL lvl_rereq got=%0d/%h exp=1/0008", n, l_vec); end
    rst = 1'b1;
    idle(1);
    checks++;
    if ({l_req, l_vec, l_id, l_ie, l_pend, l_isvc} !== '0 || {d_req, d_vec, d_id, d_ie, d_pend, d_isvc} !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%h/%h exp=0/0", {l_req, l_vec, l_id, l_ie, l_pend, l_isvc}, {d_req, d_vec, d_id, d_ie, d_pend, d_isvc});
    end
    int_in = 2'b00;
    idle(1);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [22:0] got, exp;
    int bad;
    bad = 0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int c = 0; c < 3000 && bad < 20; c++) begin
      @(negedge clk);
      got = {d_req, d_vec, d_id, d_ie, d_pend, d_isvc};
      exp = {m_req, m_req ? 16'(4 + 4 * m_id) : 16'h0, m_req ? 1'(m_id) : 1'b0, m_ie, m_pend, m_isvc};
      checks++;
      if (got !== exp) begin
        failures++;
        bad++;
        $display("FAIL rand_cyc%0d got=%h exp=%h", c, got, exp);
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) int_in[i] = ~int_in[i];
      end
      ei = ($urandom_range(0, 11) == 0);
      di = ($urandom_range(0, 11) == 0);
      reti = ($urandom_range(0, 7) == 0);
      ack = ($urandom_range(0, 3) == 0);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_din = N'($urandom);
    end
    {ei, di, reti, ack, mask_we} = '0;
    int_in = '0;
  endtask

  initial begin
    test_reset();
    test_nmi();
    test_ie_gate();
    test_nested();
    test_simultaneous();
    test_withdraw();
    test_level_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
